// File: rtl/hidden_cpu_pkg.sv
// Shared opcodes, branch conditions and instruction field helpers for the hidden CPU core.
// The field helpers take the instruction zero-extended to 32 bits plus the register-index width.
package hidden_cpu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_BR  = 2'b11;

    localparam logic [1:0] BR_UNC = 2'b00;
    localparam logic [1:0] BR_CF  = 2'b01;
    localparam logic [1:0] BR_BF  = 2'b10;
    localparam logic [1:0] BR_TOG = 2'b11;

    localparam int INSTR_MAX_W = 32;

    function automatic logic [1:0] instrOp(input logic [INSTR_MAX_W-1:0] word, input int addrW);
        logic [INSTR_MAX_W-1:0] shifted;
        shifted = word >> (2 * addrW);
        return shifted[1:0];
    endfunction

    // Register fields come back in 8 bits; callers narrow them to their own index width.
    function automatic logic [7:0] instrRd(input logic [INSTR_MAX_W-1:0] word, input int addrW);
        logic [INSTR_MAX_W-1:0] shifted;
        shifted = (word >> addrW) & ((32'd1 << addrW) - 32'd1);
        return shifted[7:0];
    endfunction

    function automatic logic [7:0] instrRs(input logic [INSTR_MAX_W-1:0] word, input int addrW);
        logic [INSTR_MAX_W-1:0] masked;
        masked = word & ((32'd1 << addrW) - 32'd1);
        return masked[7:0];
    endfunction

endpackage

// File: rtl/hidden_cpu_alu.sv
// Combinational datapath of the hidden CPU: arithmetic results, flag updates and branch decision.
module hidden_cpu_alu
    import hidden_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [1:0]        brCond_i,
    input  logic              carry_i,
    input  logic              borrow_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o,
    output logic              borrow_o,
    output logic              regWe_o,
    output logic              carryWe_o,
    output logic              borrowWe_o,
    output logic              brTaken_o,
    output logic              selToggle_o
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum         = {1'b0, a_i} + {1'b0, b_i};
        result_o    = sum[DATA_W-1:0];
        carry_o     = carry_i;
        borrow_o    = borrow_i;
        regWe_o     = 1'b0;
        carryWe_o   = 1'b0;
        borrowWe_o  = 1'b0;
        brTaken_o   = 1'b0;
        selToggle_o = 1'b0;
        case (op_i)
            OP_ADD: begin
                regWe_o   = 1'b1;
                carryWe_o = 1'b1;
                carry_o   = sum[DATA_W];
            end
            OP_SUB: begin
                result_o   = a_i - b_i;
                regWe_o    = 1'b1;
                borrowWe_o = 1'b1;
                borrow_o   = (a_i < b_i);
            end
            OP_XOR: begin
                result_o = a_i ^ b_i;
                regWe_o  = 1'b1;
            end
            default: begin
                // Branches decide on the registered flags, so they see the previous ADD/SUB.
                case (brCond_i)
                    BR_UNC:  brTaken_o   = 1'b1;
                    BR_CF:   brTaken_o   = carry_i;
                    BR_BF:   brTaken_o   = borrow_i;
                    default: selToggle_o = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/hidden_cpu_core.sv
// Parametrised hidden CPU: one-deep decode register, register file, pc, flags and output select.
// Define HIDDENCPU_STALL_EN to add a stall input that withholds instr_ready.
module hidden_cpu_core
    import hidden_cpu_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int NREG    = 4,
    parameter  int PC_W    = 8,
    localparam int ADDR_W  = $clog2(NREG),
    localparam int INSTR_W = 2 + 2 * ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
`ifdef HIDDENCPU_STALL_EN
    input  logic               stall,
`endif
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc_out,
    output logic [DATA_W-1:0]  dout,
    output logic               sel_out,
    output logic               carry_out,
    output logic               borrow_out
);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic              carry_q, carry_d;
    logic              borrow_q, borrow_d;
    logic              sel_q, sel_d;
    logic              dValid_q, dValid_d;
    logic [1:0]        dOp_q, dOp_d;
    logic [ADDR_W-1:0] dRd_q, dRd_d;
    logic [ADDR_W-1:0] dRs_q, dRs_d;
    logic [PC_W-1:0]   dTag_q, dTag_d;

    logic [INSTR_MAX_W-1:0] instrWord;
    logic                   instrReady;
    logic                   accept;
    logic                   branchTaken;
    logic [DATA_W-1:0]      aluResult;
    logic                   aluCarry, aluBorrow;
    logic                   regWe, carryWe, borrowWe, brTaken, selToggle;

`ifdef HIDDENCPU_STALL_EN
    assign instrReady = ~rst & ~stall;
`else
    assign instrReady = ~rst;
`endif

    assign instrWord   = INSTR_MAX_W'(instr);
    assign accept      = instr_valid & instrReady;
    assign branchTaken = dValid_q & brTaken;

    hidden_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i        (dOp_q),
        .a_i         (regs_q[dRd_q]),
        .b_i         (regs_q[dRs_q]),
        .brCond_i    (2'(dRs_q)),
        .carry_i     (carry_q),
        .borrow_i    (borrow_q),
        .result_o    (aluResult),
        .carry_o     (aluCarry),
        .borrow_o    (aluBorrow),
        .regWe_o     (regWe),
        .carryWe_o   (carryWe),
        .borrowWe_o  (borrowWe),
        .brTaken_o   (brTaken),
        .selToggle_o (selToggle)
    );

    always_comb begin
        regs_d   = regs_q;
        pc_d     = pc_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        sel_d    = sel_q;
        dValid_d = 1'b0;
        dOp_d    = dOp_q;
        dRd_d    = dRd_q;
        dRs_d    = dRs_q;
        dTag_d   = dTag_q;

        if (dValid_q) begin
            if (regWe)     regs_d[dRd_q] = aluResult;
            if (carryWe)   carry_d       = aluCarry;
            if (borrowWe)  borrow_d      = aluBorrow;
            if (selToggle) sel_d         = ~sel_q;
        end

        if (accept) begin
            pc_d     = pc_q + PC_W'(1);
            dValid_d = ~branchTaken;
            dOp_d    = instrOp(instrWord, ADDR_W);
            dRd_d    = ADDR_W'(instrRd(instrWord, ADDR_W));
            dRs_d    = ADDR_W'(instrRs(instrWord, ADDR_W));
            dTag_d   = pc_q;
        end

        // A taken branch wins over the sequential increment and squashes the same-cycle accept.
        if (branchTaken) pc_d = dTag_q + PC_W'(regs_q[NREG-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            sel_q    <= 1'b0;
            dValid_q <= 1'b0;
            dOp_q    <= '0;
            dRd_q    <= '0;
            dRs_q    <= '0;
            dTag_q   <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= DATA_W'(i);
        end else begin
            pc_q     <= pc_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            sel_q    <= sel_d;
            dValid_q <= dValid_d;
            dOp_q    <= dOp_d;
            dRd_q    <= dRd_d;
            dRs_q    <= dRs_d;
            dTag_q   <= dTag_d;
            regs_q   <= regs_d;
        end
    end

    assign instr_ready = instrReady;
    assign pc_out      = pc_q;
    assign dout        = sel_q ? DATA_W'(pc_q) : regs_q[NREG-1];
    assign sel_out     = sel_q;
    assign carry_out   = carry_q;
    assign borrow_out  = borrow_q;

endmodule

// File: tb/tb_hidden_cpu_core.sv
// Self-checking bench for hidden_cpu_core (default build, 8-bit data, 4 registers, 8-bit pc).
// Directed sequences plus random instructions are compared against an instruction-level model.
module tb_hidden_cpu_core;

    localparam int DATA_W = 8;
    localparam int NREG   = 4;
    localparam int PC_W   = 8;
    localparam int DMOD   = 1 << DATA_W;
    localparam int PMOD   = 1 << PC_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              instr_valid;
    logic              instr_ready;
    logic [5:0]        instr;
    logic [PC_W-1:0]   pc_out;
    logic [DATA_W-1:0] dout;
    logic              sel_out;
    logic              carry_out;
    logic              borrow_out;

    int vectors     = 0;
    int miscompares = 0;

    int mReg [NREG];
    int mPc, mCarry, mBorrow, mSel;
    bit pendValid;
    int pendOp, pendRd, pendRs, pendTag;

    always #5 clk = ~clk;

    hidden_cpu_core #(.DATA_W(DATA_W), .NREG(NREG), .PC_W(PC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .pc_out      (pc_out),
        .dout        (dout),
        .sel_out     (sel_out),
        .carry_out   (carry_out),
        .borrow_out  (borrow_out)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [5:0] enc(input int op, input int rd, input int rs);
        return 6'((op << 4) | (rd << 2) | rs);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NREG; i++) mReg[i] = i % DMOD;
        mPc       = 0;
        mCarry    = 0;
        mBorrow   = 0;
        mSel      = 0;
        pendValid = 0;
    endtask

    // One clock edge of the architecture: execute whatever was accepted last edge, then accept.
    task automatic modelStep(input bit valid, input int word);
        int a, b, oldPc;
        bit taken;
        taken = 0;
        oldPc = mPc;
        if (pendValid) begin
            a = mReg[pendRd];
            b = mReg[pendRs];
            case (pendOp)
                0: begin
                    mCarry       = ((a + b) >= DMOD) ? 1 : 0;
                    mReg[pendRd] = (a + b) % DMOD;
                end
                1: begin
                    mBorrow      = (a < b) ? 1 : 0;
                    mReg[pendRd] = (a - b + DMOD) % DMOD;
                end
                2: mReg[pendRd] = a ^ b;
                default: begin
                    if (pendRs == 0) taken = 1;
                    else if (pendRs == 1) taken = (mCarry != 0);
                    else if (pendRs == 2) taken = (mBorrow != 0);
                    else mSel = 1 - mSel;
                end
            endcase
        end
        if (taken) mPc = (pendTag + (mReg[NREG-1] % PMOD)) % PMOD;
        else if (valid) mPc = (mPc + 1) % PMOD;
        pendValid = valid && !taken;
        if (valid) begin
            pendOp  = (word >> 4) & 3;
            pendRd  = (word >> 2) & 3;
            pendRs  = word & 3;
            pendTag = oldPc;
        end
    endtask

    task automatic checkModel();
        checkOutput("pc_out", 32'(pc_out), 32'(mPc));
        checkOutput("dout", 32'(dout), 32'(mSel != 0 ? mPc % DMOD : mReg[NREG-1]));
        checkOutput("sel_out", 32'(sel_out), 32'(mSel));
        checkOutput("carry_out", 32'(carry_out), 32'(mCarry));
        checkOutput("borrow_out", 32'(borrow_out), 32'(mBorrow));
        checkOutput("instr_ready", 32'(instr_ready), 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_pc"}, 32'(pc_out), 32'd0);
        checkOutput({tag, "_dout"}, 32'(dout), 32'd3);
        checkOutput({tag, "_sel"}, 32'(sel_out), 32'd0);
        checkOutput({tag, "_carry"}, 32'(carry_out), 32'd0);
        checkOutput({tag, "_borrow"}, 32'(borrow_out), 32'd0);
        checkOutput({tag, "_ready"}, 32'(instr_ready), 32'd0);
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge, check at the next negedge.
    task automatic applyStimulus(input bit valid, input logic [5:0] word);
        instr_valid = valid;
        instr       = word;
        @(posedge clk);
        modelStep(valid, int'(word));
        @(negedge clk);
        checkModel();
    endtask

    // Reset asserted between edges must clear outputs before any clock edge arrives.
    task automatic midReset();
        instr_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkResetValues("async_rst");
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;
        modelReset();
        #1;
        checkOutput("ready_after_reset", 32'(instr_ready), 32'd1);
        @(negedge clk);
        checkModel();

        applyStimulus(1'b1, enc(0, 3, 1));
        applyStimulus(1'b1, enc(0, 3, 3));
        checkOutput("add_r3_r1", 32'(dout), 32'd4);
        applyStimulus(1'b0, '0);
        checkOutput("add_r3_r3", 32'(dout), 32'd8);
        checkOutput("add_carry", 32'(carry_out), 32'd0);

        applyStimulus(1'b1, enc(3, 0, 0));
        applyStimulus(1'b1, enc(2, 3, 3));
        checkOutput("br_target", 32'(pc_out), 32'd10);
        applyStimulus(1'b0, '0);
        checkOutput("flush_r3", 32'(dout), 32'd8);

        applyStimulus(1'b1, enc(1, 1, 2));
        applyStimulus(1'b0, '0);
        checkOutput("sub_borrow", 32'(borrow_out), 32'd1);

        applyStimulus(1'b1, enc(3, 0, 3));
        applyStimulus(1'b0, '0);
        checkOutput("sel_toggle", 32'(sel_out), 32'd1);
        checkOutput("dout_is_pc", 32'(dout), 32'd12);
        applyStimulus(1'b1, enc(3, 0, 3));
        applyStimulus(1'b0, '0);

        applyStimulus(1'b1, enc(0, 3, 3));
        midReset();
        applyStimulus(1'b0, '0);
        checkOutput("inflight_discarded", 32'(dout), 32'd3);

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 149) == 0) midReset();
            else applyStimulus($urandom_range(0, 3) != 0, 6'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hidden_cpu_core.md
Name: hidden_cpu_core

Overview:
- Parametrised successor to the 2-bit-opcode hidden CPU.
- Generalised data width, register count and PC width; one-deep decode register with valid/ready instruction handshake; branch flush.
- Single destination writeback: only rd is written; all other registers hold.
- Sits behind the TinyTapeout pin wrapper, which feeds `instr` from io_in and drives io_out from `dout`.

Parameters:
- DATA_W, 8, register/ALU width.
- NREG, 4, number of general registers; power of two, ≥2. ADDR_W = $clog2(NREG).
- PC_W, 8, program counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  `instr` holds an instruction.
- instr_ready  out  1  core accepts `instr` this cycle.
- instr  in  2+2*ADDR_W  fields {op[1:0], rd[ADDR_W-1:0], rs[ADDR_W-1:0]}, op in the MSBs.
- pc_out  out  PC_W  fetch address of the next instruction expected.
- dout  out  DATA_W  sel_out ? pc (zero-extended or truncated to DATA_W) : r[NREG-1].
- sel_out  out  1  current output select.
- carry_out  out  1  registered carry flag.
- borrow_out  out  1  registered borrow flag.

Behaviour:
- Reset (asynchronous, active-high rst), all held while rst=1:
  - pc=0; r[i]=i mod 2^DATA_W; carry=0; borrow=0; sel_out=0.
  - Decode register invalid.
- Pipeline:
  - Accept occurs when instr_valid & instr_ready. The accepted instruction and its tag (current pc) load into the decode register, valid=1.
  - On the next cycle the decode register is in execute; results are visible at the following edge.
  - Latency: an accepted instruction's writeback or flags are visible 2 edges after acceptance.
- instr_ready = 1 outside reset (macro variant below).
- pc: +1 (mod 2^PC_W) on each accept. A taken branch in execute overrides this (priority): pc <= tag + r[NREG-1][PC_W-1:0], mod 2^PC_W.
- Flush: an instruction accepted in the same cycle a branch is taken loads with valid=0. It is not replayed; the source refetches at the new pc_out.
- Execute, when valid (rd, rs read from the register file at execute):
  - op 00 ADD: r[rd] <= r[rd]+r[rs] (low DATA_W bits); carry <= bit DATA_W of the sum; borrow unchanged.
  - op 01 SUB: r[rd] <= r[rd]-r[rs]; borrow <= (r[rd] < r[rs]) unsigned; carry unchanged.
  - op 10 XOR: r[rd] <= r[rd]^r[rs]; flags unchanged.
  - op 11 BR: condition from rs[1:0]; no writeback; flags unchanged.
    - 00 unconditional taken.
    - 01 taken if carry.
    - 10 taken if borrow.
    - 11 toggle sel_out; no pc change, no flush.
    - For NREG=2, rs is 1 bit and is zero-extended.
- Flags are evaluated from their registered values, so a BR immediately after ADD/SUB sees that ADD/SUB's result.
- rd == rs is legal: e.g. SUB r,r yields 0 and borrow=0.
- Invalid decode entry: no state change except pc/accept logic.
- rst asserted mid-operation: immediate return to reset state. The in-flight instruction is discarded.

Optional Feature:
- Macro HIDDENCPU_STALL_EN.
- Defined:
  - Extra input port `stall` (1 bit): instr_ready = ~stall.
  - While stall=1, the decode register advances to invalid after its execute. Registers, pc and flags are otherwise frozen.
- Undefined: no `stall` port; instr_ready = 1 outside reset.

Decomposition:
- Package hidden_cpu_pkg holds:
  - opcode localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_XOR=2'b10, OP_BR=2'b11;
  - branch condition localparams BR_UNC, BR_CF, BR_BF, BR_TOG;
  - the instruction field-slicing helper functions.
- Sub-module hidden_cpu_alu: combinational; op, a, b → result, carry, borrow, branch-cond decode.
- Core holds all sequential state: register file, pc, decode register, flags, sel_out.

Test Plan:
- Reset then idle: pc_out=0, dout=3, r={0,1,2,3}, sel_out=0, flags 0, instr_ready=1.
- ADD r3,r1 then ADD r3,r3 (defaults 8/4/8): dout 4 then 8, carry 0. Load r0=0xFF via XOR sequence; ADD r0,r1 → r0=0x00, carry=1.
- SUB r1,r2 (1-2) → r1=0xFF, borrow=1. Next BR cond=10 with r3=3, tag 5 → pc_out=8. The instruction accepted in the branch cycle is not executed (its rd unchanged).
- BR cond=01 with carry=0 → not taken, pc increments normally, no flush. BR cond=11 → sel_out=1, dout=pc_out.
- pc wrap: r3=0xFE, BR unconditional at tag 0x05 → pc_out=0x03.
- Assert rst mid-stream with a valid decode entry → outputs return to reset values asynchronously, before the next clk edge. With HIDDENCPU_STALL_EN: stall=1 for 3 cycles → instr_ready=0, pc_out and registers frozen.
